// File: rtl/pot_scan_sched.sv
// pot_scan_sched: conversion scheduler for the shared SPI A2D master.
// Round-robin scan of the six slide pots (LP,B1,B2,B3,HP,VOL) with
// interleaved auxiliary conversions, each conversion being a channel
// command transaction followed by a read transaction.
// Optional build macro: SCAN_FILT_EN -- when defined, scan results are
// smoothed as (old + new) >> 1 after the first update of each channel.
module pot_scan_sched #(
    parameter int GAP_CYC = 8,
    parameter int TMO_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_resp,
    input  logic        aux_req,
    input  logic [2:0]  aux_chnl,
    output logic        aux_rdy,
    output logic [11:0] aux_data,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        tmo
);

    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [7:0]    GAP_LAST = 8'(GAP_CYC);

    typedef enum logic [2:0] {
        S_GAP,
        S_CMD,
        S_WAIT1,
        S_SETTLE,
        S_READ,
        S_WAIT2,
        S_UPDATE
    } state_t;

    state_t            state;
    logic [7:0]        gap_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic [2:0]        scan_idx;
    logic              slot_aux;   // current (and, once done, previous) slot was aux
    logic [11:0]       hold_q;
    logic [5:0][11:0]  pot_q;
    logic [11:0]       pot_next;
    logic              take_aux;
    logic [2:0]        pick_chnl;
    logic [2:0]        next_idx;

    // Upper response bits carry no result information.
    logic unused_resp;
    assign unused_resp = ^spi_resp[15:12];

    // A2D channel for each scan position, LP first, VOL last.
    function automatic logic [2:0] scan_chnl(input logic [2:0] idx);
        logic [2:0] ch;
        case (idx)
            3'd0:    ch = 3'd1;
            3'd1:    ch = 3'd0;
            3'd2:    ch = 3'd4;
            3'd3:    ch = 3'd2;
            3'd4:    ch = 3'd3;
            default: ch = 3'd7;
        endcase
        return ch;
    endfunction

    // Slot choice at the end of the gap: aux never takes two slots in a row.
    always_comb begin
        take_aux  = aux_req && !slot_aux;
        pick_chnl = take_aux ? aux_chnl : scan_chnl(scan_idx);
        next_idx  = (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
    end

`ifdef SCAN_FILT_EN
    logic [5:0]  pot_vld;
    logic [12:0] pot_sum;

    // Running average; a channel's first result after reset is taken as-is.
    always_comb begin
        pot_sum  = {1'b0, pot_q[scan_idx]} + {1'b0, hold_q};
        pot_next = pot_vld[scan_idx] ? pot_sum[12:1] : hold_q;
    end
`else
    // Unfiltered: the new result replaces the old one.
    always_comb pot_next = hold_q;
`endif

    // Conversion sequencer with registered SPI strobes and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_GAP;
            gap_cnt  <= 8'd0;
            tmo_cnt  <= '0;
            scan_idx <= 3'd0;
            slot_aux <= 1'b0;
            hold_q   <= 12'h000;
            pot_q    <= '0;
            spi_wrt  <= 1'b0;
            spi_cmd  <= 16'h0000;
            aux_rdy  <= 1'b0;
            aux_data <= 12'h000;
            tmo      <= 1'b0;
`ifdef SCAN_FILT_EN
            pot_vld  <= 6'd0;
`endif
        end else begin
            spi_wrt <= 1'b0;
            spi_cmd <= 16'h0000;
            aux_rdy <= 1'b0;
            tmo     <= 1'b0;
            case (state)
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= 8'd0;
                        slot_aux <= take_aux;
                        spi_wrt  <= 1'b1;
                        spi_cmd  <= {2'b00, pick_chnl, 11'h000};
                        state    <= S_CMD;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_CMD: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT1;
                end
                S_WAIT1: begin
                    if (spi_done) begin
                        state <= S_SETTLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo   <= 1'b1;
                        state <= S_GAP;
                        if (!slot_aux)
                            scan_idx <= next_idx;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                S_SETTLE: begin
                    spi_wrt <= 1'b1;
                    spi_cmd <= 16'h0000;
                    state   <= S_READ;
                end
                S_READ: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT2;
                end
                S_WAIT2: begin
                    if (spi_done) begin
                        hold_q <= spi_resp[11:0];
                        state  <= S_UPDATE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo   <= 1'b1;
                        state <= S_GAP;
                        if (!slot_aux)
                            scan_idx <= next_idx;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                S_UPDATE: begin
                    if (slot_aux) begin
                        aux_data <= hold_q;
                        aux_rdy  <= 1'b1;
                    end else begin
                        pot_q[scan_idx] <= pot_next;
`ifdef SCAN_FILT_EN
                        pot_vld[scan_idx] <= 1'b1;
`endif
                        scan_idx <= next_idx;
                    end
                    state <= S_GAP;
                end
                default: state <= S_GAP;
            endcase
        end
    end

    assign POT_LP = pot_q[0];
    assign POT_B1 = pot_q[1];
    assign POT_B2 = pot_q[2];
    assign POT_B3 = pot_q[3];
    assign POT_HP = pot_q[4];
    assign VOLUME = pot_q[5];

endmodule

// File: doc/pot_scan_sched.md
# pot_scan_sched

Conversion scheduler for the equalizer's shared SPI A2D master. Continuously scans the six slide-pot channels round-robin, issuing the two-transaction A2D protocol for each conversion. It interleaves on-demand conversions from an auxiliary requester and publishes registered 12-bit results to the filter and volume datapath. It sits between the SPI master and the band-gain / volume consumers, and owns all A2D sequencing.

## Interface
- GAP_CYC, 8: idle cycles between the end of one conversion and the start of the next (0..255).
- TMO_CYC, 4096: maximum cycles to wait for spi_done in any wait state before aborting the conversion.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- spi_wrt  out  1  one-cycle pulse that starts an SPI transaction.
- spi_cmd  out  16  command word; valid on the cycle spi_wrt is high.
- spi_done  in  1  one-cycle pulse from the SPI master when a transaction completes.
- spi_resp  in  16  response word; valid when spi_done is high; the result is bits [11:0].
- aux_req  in  1  level request for an auxiliary conversion; held until aux_rdy.
- aux_chnl  in  3  channel for the aux conversion; sampled when the aux slot starts.
- aux_rdy  out  1  one-cycle pulse when aux_data is valid.
- aux_data  out  12  aux result; holds its value until the next aux_rdy.
- POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME  out  12 each  latest scan results.
- tmo  out  1  one-cycle pulse when a conversion is aborted by timeout.

## Operation
- Scan order and A2D channels: LP=1, B1=0, B2=4, B3=2, HP=3, VOL=7. The scan index wraps from VOL back to LP.
- A conversion is two transactions:
  - First transaction: spi_cmd = {2'b00, chnl, 11'h000}; its response is ignored.
  - Second transaction: spi_cmd = 16'h0000; spi_resp[11:0] is the result.
- FSM states:
  - GAP: counts GAP_CYC cycles. At the end it picks the slot and goes to CMD.
  - CMD: pulses spi_wrt with the channel command, then goes to WAIT1.
  - WAIT1: on spi_done, goes to SETTLE.
  - SETTLE: one cycle, then goes to READ.
  - READ: pulses spi_wrt with 16'h0000, then goes to WAIT2.
  - WAIT2: on spi_done, goes to UPDATE.
  - UPDATE: writes the result, then goes to GAP.
- Slot selection at the end of GAP:
  - If aux_req=1 and the previous completed slot was not aux, the slot is aux (aux_chnl latched).
  - Otherwise the slot is the current scan channel.
  - Aux therefore never takes two consecutive slots, and the scan is never starved.
- UPDATE, scan slot: the target POT_x register is written and the scan index advances.
- UPDATE, aux slot: aux_data is written and aux_rdy pulses; the scan index does not advance.
- Timeout:
  - The timeout counter clears on entry to WAIT1 and WAIT2.
  - When it reaches TMO_CYC-1 without spi_done: pulse tmo, return to GAP, leave outputs unchanged.
  - A timed-out scan slot still advances the index.
  - A timed-out aux slot leaves aux_req pending and counts as "previous slot aux". The scan slot runs next, then aux is retried.
- spi_done seen in any state other than WAIT1/WAIT2 is ignored.

## Timing
- All outputs reset to 0: POT_* = 12'h000, aux_data = 12'h000, spi_wrt = 0, spi_cmd = 16'h0000, aux_rdy = 0, tmo = 0.
- After reset the FSM is in GAP with the scan index at LP and "previous slot aux" = 0.
- The first spi_wrt occurs GAP_CYC+1 cycles after rst_n is first sampled high.
- After spi_done in WAIT1, spi_wrt for the read goes high 2 cycles later (SETTLE, then READ).
- Results appear 2 cycles after spi_done in WAIT2: spi_resp[11:0] is captured into a holding register on the spi_done edge, and the UPDATE register write lands one edge later. aux_rdy is asserted with that same write.
- Full scan period: 6 × (GAP_CYC + 5 + 2 × SPI transaction time) when aux is idle.
- Reset asserted mid-transaction: all state clears on that edge. The SPI master is reset by the same rst_n, so a partial transaction is discarded.

## Configuration
- SCAN_FILT_EN defined:
  - Each scan update writes POT_x = (POT_x + new) >> 1, using a 13-bit sum truncated to 12 bits.
  - The first update after reset writes new directly; a per-channel valid bit tracks this.
  - aux_data is never filtered.
- SCAN_FILT_EN undefined: POT_x = new. No valid bits or adders are synthesized.

## Test plan
- Scan order: SPI model returns 12'h100 + chnl. Required: channel commands in the order 1, 0, 4, 2, 3, 7, 1. Results POT_LP=12'h101, POT_B1=12'h100, POT_B2=12'h104, POT_B3=12'h102, POT_HP=12'h103, VOLUME=12'h107.
- Aux interleave: hold aux_req=1 with aux_chnl=5 over 3 slots. Required slot pattern: aux, scan, aux. Each aux slot gives aux_rdy with aux_data=12'h105, and the scan index advances only on scan slots.
- Timeout: SPI model withholds spi_done for the B2 first transaction, with TMO_CYC=16. Required: tmo pulses 16 cycles after WAIT1 entry, POT_B2 stays at its old value, and the next command is channel 2.
- Reset mid-operation: drop rst_n while in WAIT2 for HP. Required: all outputs 0 on the next edge, and the first command after release is channel 1.
- SCAN_FILT_EN: LP returns 12'h200, then 12'h400. Required: POT_LP=12'h200, then 12'h300. With the macro undefined: 12'h200, then 12'h400.
- Wrap/boundary: return 12'hFFF on every channel. Required: every POT_x=12'hFFF, including after filtered updates (no overflow).
